axi_mat_accel: RTL and testbench
================================

Name: axi_mat_accel

Overview:
Streaming integer matrix-multiply accelerator computing C[MxN] = A[MxK] x B[KxN].
- An AXI-Lite slave holds the configuration and the start/done control registers.
- A and B arrive row-major on two AXI-Stream slaves; C leaves row-major on an AXI-Stream master.
- Sits as a memory-mapped peripheral between a CPU control bus and DMA stream engines.

Parameters:
DATA_W, 32, AXI-Lite data and stream element width.
ADDR_W, 32, AXI-Lite address width.
MAX_DIM, 4, maximum value of M, K and N; sizes the internal A, B and C buffers.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous reset, active-high.
s_axi_awvalid/awready  in/out  1  write address handshake; s_axi_awaddr  in  ADDR_W.
s_axi_wvalid/wready  in/out  1  write data handshake; s_axi_wdata  in  DATA_W.
s_axi_bvalid  out  1; s_axi_bready  in  1; s_axi_bresp  out  2.
s_axi_arvalid/arready  in/out  1; s_axi_araddr  in  ADDR_W.
s_axi_rvalid  out  1; s_axi_rready  in  1; s_axi_rdata  out  DATA_W; s_axi_rresp  out  2.
s_axis_a_tvalid/tready/tlast  in/out/in  1; s_axis_a_tdata  in  DATA_W.
s_axis_b_tvalid/tready/tlast  in/out/in  1; s_axis_b_tdata  in  DATA_W.
m_axis_c_tvalid/tready/tlast  out/in/out  1; m_axis_c_tdata  out  DATA_W.
done  out  1  high while in DONE state.

Behaviour:
Register map (word offsets):
- 0x00 START: writing bit0=1 issues a 1-cycle start pulse; writing 0 has no effect; reads 0.
- 0x04 DONE: bit0 = done; read-only.
- 0x08 CFG_M, 0x0C CFG_K, 0x10 CFG_N: reset to 2.
- A config write of 0 or a value >MAX_DIM is rejected: register unchanged, bresp=SLVERR (2'b10).
- Unmapped address or write to DONE: bresp=SLVERR on write; read returns rdata 0 with rresp=SLVERR. Otherwise resp=OKAY.

AXI-Lite handshakes:
- Write: awready=wready=!bvalid (combinational). The write commits on the cycle awvalid&&wvalid&&awready. bvalid is set the next cycle and held until bready.
- Read: arready=!rvalid. rvalid/rdata are registered the cycle after the arvalid&&arready handshake and held until rready.

FSM states: IDLE, LOAD, COMPUTE, OUTPUT, DONE.
- Start accepted only in IDLE or DONE: M/K/N are latched, a_cnt=b_cnt=0, done cleared, go to LOAD. Start in LOAD/COMPUTE/OUTPUT is ignored (write still OKAY).
- LOAD:
  - s_axis_a_tready = (a_cnt < M*K). Each A handshake stores tdata at index a_cnt and increments a_cnt.
  - s_axis_b_tready = (b_cnt < K*N), with the same rule for B.
  - The A and B streams are independent and may interleave arbitrarily. tlast is ignored; the beat count is authoritative.
  - When both counts are complete, go to COMPUTE.
- COMPUTE: one MAC per cycle, C[i][j] += A[i][k]*B[k][j], iterating k innermost, then j, then i. Takes M*N*K cycles, then go to OUTPUT.
- Arithmetic: unsigned, product truncated to DATA_W, accumulation modulo 2^DATA_W.
- OUTPUT:
  - C is streamed row-major: tvalid high, tdata/tlast stable until tready.
  - tlast is asserted on beat M*N-1.
  - Arbitrary tready backpressure must lose no beat.
  - After the last handshake, go to DONE.
- DONE: done=1 and the DONE register reads 1 until the next start or reset.
- In states other than LOAD, both A and B tready=0. Outside OUTPUT, m_axis_c_tvalid=0.
- Reset values (any time, including mid-LOAD/COMPUTE/OUTPUT):
  - All readies/valids 0, except awready/wready/arready which follow their formulas.
  - done=0, state IDLE, counters 0, config registers 2, bresp/rresp 0.
  - Buffer contents are don't-care.
  - Stream beats presented during reset are dropped.

Decomposition:
- Package axi_mat_pkg: register offset constants, RESP_OKAY/RESP_SLVERR, the state enum, and the default dimension value.
- Sub-module axi_mat_compute: FSM, buffers, MAC and streams.
- The top level holds the AXI-Lite register file.

Test Plan:
- Reset, write CFG_K=2 (M=N=2 default), START=1, send A=0,1,2,3 and B=0,1,2,3 with random valid gaps -> C=2,3,6,11, tlast on 4th beat, done=1, all bresp OKAY.
- After a completed run, read 0x04 -> rdata bit0=1, rresp OKAY.
- Assert rst while in COMPUTE -> state IDLE, done=0, readies 0. Then repeat the basic flow -> identical C.
- Three back-to-back runs (START=1, streams, DONE, START=0 write) with random C tready -> each yields 2,3,6,11 with no dropped or duplicated beats.
- START written while done=1 -> done clears, LOAD entered, new run completes normally. START during LOAD is ignored.
- Write CFG_M=0, CFG_N=5 and read 0x14 -> bresp SLVERR, registers stay 2, read returns 0 with rresp SLVERR.

Source files
------------

// File: rtl/axi_mat_pkg.sv
// Shared constants and types for the AXI matrix-multiply accelerator.
package axi_mat_pkg;
  localparam logic [7:0] REG_START = 8'h00;
  localparam logic [7:0] REG_DONE  = 8'h04;
  localparam logic [7:0] REG_CFG_M = 8'h08;
  localparam logic [7:0] REG_CFG_K = 8'h0C;
  localparam logic [7:0] REG_CFG_N = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_DIM = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_OUTPUT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/axi_mat_compute.sv
// Control FSM, operand/result buffers, single MAC and the three streams.
module axi_mat_compute
  import axi_mat_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic              m_axis_c_tlast,
  output logic [DATA_W-1:0] m_axis_c_tdata,
  output logic              done
);
  localparam int NBUF  = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NBUF + 1);
  localparam int BI_W  = (NBUF > 1) ? $clog2(NBUF) : 1;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic [IDX_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] a_buf_q [NBUF], a_buf_d [NBUF];
  logic [DATA_W-1:0] b_buf_q [NBUF], b_buf_d [NBUF];
  logic [DATA_W-1:0] c_buf_q [NBUF], c_buf_d [NBUF];

  logic [IDX_W-1:0]  mk, kn, mn;
  logic [BI_W-1:0]   a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] prod;

  assign mk    = IDX_W'(m_q) * IDX_W'(k_q);
  assign kn    = IDX_W'(k_q) * IDX_W'(n_q);
  assign mn    = IDX_W'(m_q) * IDX_W'(n_q);
  assign a_idx = BI_W'(IDX_W'(i_q) * IDX_W'(k_q) + IDX_W'(kk_q));
  assign b_idx = BI_W'(IDX_W'(kk_q) * IDX_W'(n_q) + IDX_W'(j_q));
  assign c_idx = BI_W'(IDX_W'(i_q) * IDX_W'(n_q) + IDX_W'(j_q));
  assign prod  = a_buf_q[a_idx] * b_buf_q[b_idx];
  assign done  = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    k_d       = k_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    kk_d      = kk_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    out_cnt_d = out_cnt_q;
    a_buf_d   = a_buf_q;
    b_buf_d   = b_buf_q;
    c_buf_d   = c_buf_q;
    s_axis_a_tready = 1'b0;
    s_axis_b_tready = 1'b0;
    m_axis_c_tvalid = 1'b0;
    m_axis_c_tlast  = 1'b0;
    m_axis_c_tdata  = c_buf_q[BI_W'(out_cnt_q)];
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d       = cfg_m;
          k_d       = cfg_k;
          n_d       = cfg_n;
          a_cnt_d   = '0;
          b_cnt_d   = '0;
          out_cnt_d = '0;
          i_d       = '0;
          j_d       = '0;
          kk_d      = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_axis_a_tready = (a_cnt_q < mk);
        s_axis_b_tready = (b_cnt_q < kn);
        if (s_axis_a_tvalid && s_axis_a_tready) begin
          a_buf_d[BI_W'(a_cnt_q)] = s_axis_a_tdata;
          a_cnt_d = a_cnt_q + IDX_W'(1);
        end
        if (s_axis_b_tvalid && s_axis_b_tready) begin
          b_buf_d[BI_W'(b_cnt_q)] = s_axis_b_tdata;
          b_cnt_d = b_cnt_q + IDX_W'(1);
        end
        if (a_cnt_q == mk && b_cnt_q == kn) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // First k of each element overwrites, so C never needs clearing.
        c_buf_d[c_idx] = ((kk_q == '0) ? '0 : c_buf_q[c_idx]) + prod;
        if (kk_q == k_q - DIM_W'(1)) begin
          kk_d = '0;
          if (j_q == n_q - DIM_W'(1)) begin
            j_d = '0;
            if (i_q == m_q - DIM_W'(1)) begin
              i_d     = '0;
              state_d = ST_OUTPUT;
            end else begin
              i_d = i_q + DIM_W'(1);
            end
          end else begin
            j_d = j_q + DIM_W'(1);
          end
        end else begin
          kk_d = kk_q + DIM_W'(1);
        end
      end
      ST_OUTPUT: begin
        m_axis_c_tvalid = 1'b1;
        m_axis_c_tlast  = (out_cnt_q == mn - IDX_W'(1));
        if (m_axis_c_tready) begin
          if (m_axis_c_tlast) state_d = ST_DONE;
          else                out_cnt_d = out_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= DIM_W'(DEF_DIM);
      k_q       <= DIM_W'(DEF_DIM);
      n_q       <= DIM_W'(DEF_DIM);
      i_q       <= '0;
      j_q       <= '0;
      kk_q      <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      k_q       <= k_d;
      n_q       <= n_d;
      i_q       <= i_d;
      j_q       <= j_d;
      kk_q      <= kk_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Buffer contents carry no meaning across reset.
  always_ff @(posedge clk) begin
    a_buf_q <= a_buf_d;
    b_buf_q <= b_buf_d;
    c_buf_q <= c_buf_d;
  end
endmodule

// File: rtl/axi_mat_accel.sv
// AXI-Lite register file in front of the streaming matrix-multiply engine.
module axi_mat_accel
  import axi_mat_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_DIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic              s_axis_a_tlast,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic              m_axis_c_tlast,
  output logic [DATA_W-1:0] m_axis_c_tdata,
  output logic              done
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);

  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DIM_W-1:0]  cfg_m_q, cfg_m_d, cfg_k_q, cfg_k_d, cfg_n_q, cfg_n_d;
  logic              wr_en, rd_en, start, cfg_ok;
  logic              unused_tlast;

  // Beat counts are authoritative; the slave tlast inputs carry no information.
  assign unused_tlast  = s_axis_a_tlast ^ s_axis_b_tlast;
  assign s_axi_awready = !bvalid_q;
  assign s_axi_wready  = !bvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_en = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
  assign rd_en = s_axi_arvalid && !rvalid_q;
  assign cfg_ok = (s_axi_wdata != '0) && (s_axi_wdata <= DATA_W'(MAX_DIM));

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    cfg_m_d  = cfg_m_q;
    cfg_k_d  = cfg_k_q;
    cfg_n_d  = cfg_n_q;
    start    = 1'b0;
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (s_axi_awaddr)
        ADDR_W'(REG_START): start = s_axi_wdata[0];
        ADDR_W'(REG_CFG_M): if (cfg_ok) cfg_m_d = s_axi_wdata[DIM_W-1:0]; else bresp_d = RESP_SLVERR;
        ADDR_W'(REG_CFG_K): if (cfg_ok) cfg_k_d = s_axi_wdata[DIM_W-1:0]; else bresp_d = RESP_SLVERR;
        ADDR_W'(REG_CFG_N): if (cfg_ok) cfg_n_d = s_axi_wdata[DIM_W-1:0]; else bresp_d = RESP_SLVERR;
        default:            bresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (s_axi_araddr)
        ADDR_W'(REG_START): rdata_d = '0;
        ADDR_W'(REG_DONE):  rdata_d = DATA_W'(done);
        ADDR_W'(REG_CFG_M): rdata_d = DATA_W'(cfg_m_q);
        ADDR_W'(REG_CFG_K): rdata_d = DATA_W'(cfg_k_q);
        ADDR_W'(REG_CFG_N): rdata_d = DATA_W'(cfg_n_q);
        default:            rresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      cfg_m_q  <= DIM_W'(DEF_DIM);
      cfg_k_q  <= DIM_W'(DEF_DIM);
      cfg_n_q  <= DIM_W'(DEF_DIM);
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      cfg_m_q  <= cfg_m_d;
      cfg_k_q  <= cfg_k_d;
      cfg_n_q  <= cfg_n_d;
    end
  end

  axi_mat_compute #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_compute (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_m           (cfg_m_q),
    .cfg_k           (cfg_k_q),
    .cfg_n           (cfg_n_q),
    .s_axis_a_tvalid (s_axis_a_tvalid),
    .s_axis_a_tready (s_axis_a_tready),
    .s_axis_a_tdata  (s_axis_a_tdata),
    .s_axis_b_tvalid (s_axis_b_tvalid),
    .s_axis_b_tready (s_axis_b_tready),
    .s_axis_b_tdata  (s_axis_b_tdata),
    .m_axis_c_tvalid (m_axis_c_tvalid),
    .m_axis_c_tready (m_axis_c_tready),
    .m_axis_c_tlast  (m_axis_c_tlast),
    .m_axis_c_tdata  (m_axis_c_tdata),
    .done            (done)
  );
endmodule

// File: tb/tb_axi_mat_accel.sv
// Directed bench: register-access vector table plus hand-written stream runs.
module tb_axi_mat_accel;
  logic        clk, rst;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        a_tvalid, a_tready, a_tlast, b_tvalid, b_tready, b_tlast;
  logic [31:0] a_tdata, b_tdata, c_tdata;
  logic        c_tvalid, c_tready, c_tlast, done;

  axi_mat_accel dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready), .s_axis_a_tlast(a_tlast),
    .s_axis_a_tdata(a_tdata),
    .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready), .s_axis_b_tlast(b_tlast),
    .s_axis_b_tdata(b_tdata),
    .m_axis_c_tvalid(c_tvalid), .m_axis_c_tready(c_tready), .m_axis_c_tlast(c_tlast),
    .m_axis_c_tdata(c_tdata),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } reg_vec_t;

  reg_vec_t    tbl[16];
  logic [31:0] a_vec[16], b_vec[16], c_exp[16];
  logic [1:0]  resp;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] r);
    int t;
    @(negedge clk);
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_awaddr = addr; s_axi_wdata = data;
    t = 0;
    while (!s_axi_awready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("awready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("bvalid_timeout", 32'd0, 32'd1);
    r = s_axi_bresp;
    @(posedge clk);
    #1 s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int t;
    @(negedge clk);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr;
    t = 0;
    while (!s_axi_arready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("arready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    t = 0;
    while (!s_axi_rvalid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("rvalid_timeout", 32'd0, 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    @(posedge clk);
    #1 s_axi_rready = 1'b0;
  endtask

  // Drives beats [from,to) of A (is_b=0) or B (is_b=1) with random idle gaps.
  task automatic send(input bit is_b, input int from, input int to);
    int t;
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (is_b) begin b_tvalid = 1'b1; b_tdata = b_vec[i]; b_tlast = (i == to - 1); end
      else      begin a_tvalid = 1'b1; a_tdata = a_vec[i]; a_tlast = (i == to - 1); end
      t = 0;
      while (!(is_b ? b_tready : a_tready) && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) begin
        check(is_b ? "b_tready_timeout" : "a_tready_timeout", 32'd0, 32'd1);
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (is_b) b_tvalid = 1'b0; else a_tvalid = 1'b0;
    end
  endtask

  task automatic collect(input int n);
    int got, t;
    got = 0; t = 0;
    while (got < n && t < 1000) begin
      @(negedge clk);
      c_tready = 1'($urandom_range(0, 1));
      t++;
      if (c_tvalid && c_tready) begin
        check($sformatf("c_data[%0d]", got), c_tdata, c_exp[got]);
        check($sformatf("c_tlast[%0d]", got), 32'(c_tlast), 32'(got == n - 1));
        got++;
      end
    end
    @(posedge clk);
    #1 c_tready = 1'b0;
    if (got < n) check("c_beats_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin @(negedge clk); t++; end
    check("done_after_run", 32'(done), 32'd1);
    check("c_tvalid_after_run", 32'(c_tvalid), 32'd0);
    check("a_tready_after_run", 32'(a_tready), 32'd0);
  endtask

  task automatic run_mat(input int na, input int nb, input int nc);
    axi_write(32'h00, 32'd1, resp);
    check("start_bresp", 32'(resp), 32'd0);
    check("done_cleared_by_start", 32'(done), 32'd0);
    fork
      send(1'b0, 0, na);
      send(1'b1, 0, nb);
      collect(nc);
    join
    wait_done();
  endtask

  task automatic set_basic();
    for (int i = 0; i < 4; i++) begin a_vec[i] = 32'(i); b_vec[i] = 32'(i); end
    c_exp[0] = 32'd2; c_exp[1] = 32'd3; c_exp[2] = 32'd6; c_exp[3] = 32'd11;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_tready"}, 32'(a_tready), 32'd0);
    check({tag, "_b_tready"}, 32'(b_tready), 32'd0);
    check({tag, "_c_tvalid"}, 32'(c_tvalid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd0);
    check({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
    check({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_rready = 0;
    a_tvalid = 0; a_tlast = 0; a_tdata = 0; b_tvalid = 0; b_tlast = 0; b_tdata = 0; c_tready = 0;

    tbl[0]  = '{1'b0, 32'h08, 32'd0, 2'b00, 32'd2};
    tbl[1]  = '{1'b0, 32'h0C, 32'd0, 2'b00, 32'd2};
    tbl[2]  = '{1'b0, 32'h10, 32'd0, 2'b00, 32'd2};
    tbl[3]  = '{1'b0, 32'h04, 32'd0, 2'b00, 32'd0};
    tbl[4]  = '{1'b1, 32'h0C, 32'd2, 2'b00, 32'd0};
    tbl[5]  = '{1'b1, 32'h08, 32'd0, 2'b10, 32'd0};
    tbl[6]  = '{1'b1, 32'h10, 32'd5, 2'b10, 32'd0};
    tbl[7]  = '{1'b0, 32'h08, 32'd0, 2'b00, 32'd2};
    tbl[8]  = '{1'b0, 32'h10, 32'd0, 2'b00, 32'd2};
    tbl[9]  = '{1'b0, 32'h14, 32'd0, 2'b10, 32'd0};
    tbl[10] = '{1'b1, 32'h14, 32'd1, 2'b10, 32'd0};
    tbl[11] = '{1'b1, 32'h04, 32'd1, 2'b10, 32'd0};
    tbl[12] = '{1'b0, 32'h00, 32'd0, 2'b00, 32'd0};
    tbl[13] = '{1'b1, 32'h00, 32'd0, 2'b00, 32'd0};
    tbl[14] = '{1'b1, 32'h0C, 32'd5, 2'b10, 32'd0};
    tbl[15] = '{1'b0, 32'h0C, 32'd0, 2'b00, 32'd2};

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, resp);
        check($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].resp));
      end else begin
        axi_read(tbl[i].addr, rd, resp);
        check($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(tbl[i].resp));
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      end
    end
    @(negedge clk);
    check("start0_no_load", 32'(a_tready), 32'd0);

    // Basic 2x2x2 run, then DONE register readback.
    set_basic();
    run_mat(4, 4, 4);
    axi_read(32'h04, rd, resp);
    check("done_reg_rdata", rd, 32'd1);
    check("done_reg_rresp", 32'(resp), 32'd0);

    // Back-to-back runs, each started from DONE and followed by a START=0 write.
    for (int r = 0; r < 3; r++) begin
      run_mat(4, 4, 4);
      axi_write(32'h00, 32'd0, resp);
      check($sformatf("b2b%0d_start0_bresp", r), 32'(resp), 32'd0);
      check($sformatf("b2b%0d_done_held", r), 32'(done), 32'd1);
    end

    // START during LOAD must not restart the beat counters.
    axi_write(32'h00, 32'd1, resp);
    check("load_start_bresp", 32'(resp), 32'd0);
    send(1'b0, 0, 2);
    axi_write(32'h00, 32'd1, resp);
    check("load_restart_bresp", 32'(resp), 32'd0);
    fork
      send(1'b0, 2, 4);
      send(1'b1, 0, 4);
      collect(4);
    join
    wait_done();

    // Non-square 3x2 * 2x1 run exercises the index arithmetic.
    axi_write(32'h08, 32'd3, resp);
    check("cfg_m3_bresp", 32'(resp), 32'd0);
    axi_write(32'h10, 32'd1, resp);
    check("cfg_n1_bresp", 32'(resp), 32'd0);
    for (int i = 0; i < 6; i++) a_vec[i] = 32'(i + 1);
    b_vec[0] = 32'd7; b_vec[1] = 32'd8;
    c_exp[0] = 32'd23; c_exp[1] = 32'd53; c_exp[2] = 32'd83;
    run_mat(6, 2, 3);

    // Reset while computing, then the basic flow again.
    axi_write(32'h00, 32'd1, resp);
    fork
      send(1'b0, 0, 6);
      send(1'b1, 0, 2);
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_compute_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_compute_reset");
    axi_read(32'h08, rd, resp);
    check("cfg_m_after_reset", rd, 32'd2);
    axi_read(32'h10, rd, resp);
    check("cfg_n_after_reset", rd, 32'd2);
    set_basic();
    axi_write(32'h0C, 32'd2, resp);
    check("cfg_k2_bresp", 32'(resp), 32'd0);
    run_mat(4, 4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
